// File: rtl/mont_word_seq_if.sv
// mont_word_seq_if
//   Groups the command and strobe signals between the AXI-side command
//   registers, the Montgomery word sequencer and the qm/MAC datapath.
//
//   master : command side. It drives start/abort/n_words and observes
//            the status and strobes.
//   slave  : the sequencer. It receives the command and drives the
//            indices and strobes.
//
//   start     command strobe, sampled only while idle
//   abort     synchronous cancel, highest priority
//   n_words   operand length in 16-bit words
//   busy      sequencer is not idle
//   done      one-cycle completion pulse
//   x_idx     outer word index i (selects X[i])
//   y_idx     inner word index j (selects Y[j], M[j])
//   qm_issue  present X[i]*Y[0] and S0 to the Q' generator
//   qm_latch  datapath captures Q_m at the end of this cycle
//   mac_en    accumulate step for word j
//   mac_first j==0 during mac_en (low word discarded)
//   mac_last  j==n-1 during mac_en
//   carry_en  store the accumulator carry as the top S word
interface mont_word_seq_if #(
    parameter int NW_W = 6
);
    logic            start;
    logic            abort;
    logic [NW_W-1:0] n_words;
    logic            busy;
    logic            done;
    logic [NW_W-1:0] x_idx;
    logic [NW_W-1:0] y_idx;
    logic            qm_issue;
    logic            qm_latch;
    logic            mac_en;
    logic            mac_first;
    logic            mac_last;
    logic            carry_en;

    modport master (
        output start, abort, n_words,
        input  busy, done, x_idx, y_idx,
        input  qm_issue, qm_latch, mac_en, mac_first, mac_last, carry_en
    );

    modport slave (
        input  start, abort, n_words,
        output busy, done, x_idx, y_idx,
        output qm_issue, qm_latch, mac_en, mac_first, mac_last, carry_en
    );
endinterface

// File: rtl/mont_word_seq.sv
// mont_word_seq
//   Sequencer for the word-serial Montgomery multiplier. For every outer
//   word X[i] it fires the Q' generator, waits out that generator's fixed
//   latency, sweeps the inner loop j over Y[j]/M[j], then spends one cycle
//   on the carry word. Only indices and strobes are produced; no operand
//   arithmetic happens here.
//
//   Parameters
//     NW_W    width of word counts and indices
//     QM_LAT  cycles from qm_issue to a valid Q_m (must be >= 1)
//
//   Ports
//     clk   clock, rising edge
//     rstn  asynchronous active-low reset
//     bus   mont_word_seq_if.slave (command in, indices/strobes out)
//
//   Every output is decoded from registered state only, so there is no
//   combinational path from any input to any output.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   S_IDLE     | waiting for start
//   S_QM_ISSUE | qm_issue for outer word i (one cycle)
//   S_QM_WAIT  | QM_LAT cycles; qm_latch on the last of them
//   S_MAC      | n cycles of accumulate, y_idx = j
//   S_CARRY    | store the carry word, then next i or finish
//   S_DONE     | one-cycle done pulse
module mont_word_seq #(
    parameter int NW_W   = 6,
    parameter int QM_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    mont_word_seq_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QM_ISSUE,
        S_QM_WAIT,
        S_MAC,
        S_CARRY,
        S_DONE
    } state_t;

    // The wait counter only has to reach QM_LAT-1.
    localparam int              CW       = (QM_LAT > 1) ? $clog2(QM_LAT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(QM_LAT - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [NW_W-1:0] IDX_ONE  = NW_W'(1);

    state_t          state_q, state_d;
    logic [NW_W-1:0] last_q, last_d;   // n-1, latched at start
    logic [NW_W-1:0] i_q, i_d;
    logic [NW_W-1:0] j_q, j_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            last_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        i_d     = i_q;
        j_d     = j_q;
        cnt_d   = cnt_q;

        if (bus.abort) begin
            state_d = S_IDLE;
            i_d     = '0;
            j_d     = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.n_words != '0) begin
                            // Storing n-1 lets both loop ends compare directly.
                            last_d  = bus.n_words - IDX_ONE;
                            i_d     = '0;
                            j_d     = '0;
                            state_d = S_QM_ISSUE;
                        end else begin
                            // Empty operand: finish without any strobes.
                            state_d = S_DONE;
                        end
                    end
                end

                S_QM_ISSUE: begin
                    cnt_d   = '0;
                    j_d     = '0;
                    state_d = S_QM_WAIT;
                end

                S_QM_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        j_d     = '0;
                        state_d = S_MAC;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                S_MAC: begin
                    if (j_q == last_q) begin
                        j_d     = '0;
                        state_d = S_CARRY;
                    end else begin
                        j_d = j_q + IDX_ONE;
                    end
                end

                S_CARRY: begin
                    if (i_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + IDX_ONE;
                        state_d = S_QM_ISSUE;
                    end
                end

                S_DONE: begin
                    i_d     = '0;
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                    i_d     = '0;
                    j_d     = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pure decode of registered state.
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.qm_issue  = (state_q == S_QM_ISSUE);
    assign bus.qm_latch  = (state_q == S_QM_WAIT) && (cnt_q == CNT_LAST);
    assign bus.mac_en    = (state_q == S_MAC);
    assign bus.mac_first = (state_q == S_MAC) && (j_q == '0);
    assign bus.mac_last  = (state_q == S_MAC) && (j_q == last_q);
    assign bus.carry_en  = (state_q == S_CARRY);
    assign bus.x_idx     = i_q;
    assign bus.y_idx     = (state_q == S_MAC) ? j_q : '0;

endmodule

// File: doc/mont_word_seq.md
# mont_word_seq

Sequencer for the word-serial Montgomery multiplication datapath. For each 16-bit word X[i] of the multiplier, it triggers the Q' generator (Qm = (S0 + X[i]·Y[0])·M' mod 2^16) and waits that generator's fixed pipeline latency. It then sweeps the inner word loop j over Y[j]/M[j] for the accumulate step S = (S + X[i]·Y[j] + Qm·M[j]) / 2^16, followed by one carry-word cycle. It sits between the AXI-side command registers and the qm/MAC datapath, and produces only indices and strobes; it does no arithmetic on operands.

## Interface
Parameters:
- NW_W, default 6: width of word-count and index ports; operands hold up to 2^NW_W − 1 words.
- QM_LAT, default 2: cycles from `qm_issue` to a valid Q_m at the generator output; must be ≥1.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `start`  in  1  command strobe; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; has priority over all other inputs.
- `n_words`  in  NW_W  operand length in 16-bit words; latched when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at completion.
- `x_idx`  out  NW_W  outer index i, which selects X[i].
- `y_idx`  out  NW_W  inner index j, which selects Y[j] and M[j].
- `qm_issue`  out  1  presents X[i]·Y[0] and S0 to the Q' generator this cycle.
- `qm_latch`  out  1  datapath captures Q_m at the end of this cycle.
- `mac_en`  out  1  accumulate step for word j is active.
- `mac_first`  out  1  j==0 while `mac_en` is high; the low word is discarded (shift).
- `mac_last`  out  1  j==n−1 while `mac_en` is high.
- `carry_en`  out  1  store the accumulator carry as the top S word.

## Operation
- State machine: IDLE, QM_ISSUE, QM_WAIT, MAC, CARRY, DONE.
- IDLE:
  - `start`=1 with `n_words`≥1: latch n, i←0, j←0, go to QM_ISSUE.
  - `start`=1 with `n_words`==0: go to DONE directly; no strobes are issued.
- QM_ISSUE (1 cycle): `qm_issue`=1, `y_idx`=0, wait counter←0. Next state is QM_WAIT.
- QM_WAIT (QM_LAT cycles): the counter increments each cycle. `qm_latch`=1 on the cycle where counter==QM_LAT−1, then go to MAC with j←0.
- MAC (n cycles): `mac_en`=1, `y_idx`=j. `mac_first` when j==0, `mac_last` when j==n−1 (both are high when n==1). j increments each cycle; after j==n−1, go to CARRY.
- CARRY (1 cycle): `carry_en`=1.
  - If i==n−1, go to DONE.
  - Otherwise i←i+1 and go to QM_ISSUE.
- DONE (1 cycle): `done`=1, then go to IDLE.
- `abort`=1 in any state: go to IDLE at the next edge. No `done` is produced and all strobes deassert in that following cycle.
- `start` is ignored while `busy`=1. A `start` in the same cycle as `done` is ignored, because the machine is in DONE, not IDLE.
- Changes to `n_words` after a command is accepted have no effect until the next accepted `start`.
- At most one of `qm_issue`, `qm_latch`, `mac_en`, `carry_en` is high in any cycle.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`, `done`, `qm_issue`, `qm_latch`, `mac_en`, `mac_first`, `mac_last`, `carry_en` are 0.
  - `x_idx`=0, `y_idx`=0.
- Reset asserted mid-operation returns the machine to IDLE immediately (asynchronously); no `done` pulse is produced.
- All outputs are registered, or decoded from registered state only. There is no combinational path from any input to any output.
- Cycle 1 is the first cycle after the edge that accepts `start`.
- Each outer iteration lasts QM_LAT + n + 2 cycles.
- `done` is high in cycle n·(QM_LAT+n+2)+1.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- `x_idx` is stable for a whole outer iteration. `y_idx` holds 0 outside MAC.

## Test plan
- Reset: assert `rstn`=0 mid-MAC with n=3 -> all outputs go to 0 asynchronously; after release, `busy` stays 0 until a new `start`.
- Basic sequence: QM_LAT=2, start with n=2 -> `qm_issue` in cycles 1 and 7; `qm_latch` in 3 and 9; `mac_en` in 4–5 and 10–11 with `mac_first` at 4 and 10; `carry_en` at 6 and 12; `done` at 13; `x_idx`=0 for cycles 1–6 and 1 for cycles 7–12.
- Longer operand: QM_LAT=3, n=4 -> exactly 16 `mac_en` cycles and 4 `carry_en` cycles; `done` in cycle 37; the `y_idx` sequence within MAC is 0,1,2,3 in each of the 4 iterations.
- Edge lengths:
  - n=1 -> `mac_first`=`mac_last`=1 in the same cycle; `done` in cycle QM_LAT+4.
  - n=0 -> `done` in cycle 1; no strobes are issued.
- Abort: `abort` during the second QM_WAIT with n=3 -> IDLE at the next edge, `busy`=0, no `done`; a new `start` with n=1 completes normally.
- Start ignored: `start` pulsed while `busy`=1, and again in the `done` cycle -> no effect on the count or indices; state is IDLE after `done`.
